// File: rtl/window_averager_if.sv
// window_averager_if: sample taps, control and statistics bundle for the window averager
interface window_averager_if #(
    parameter int word_size = 8
);
    logic                 sample_valid;
    logic [word_size-1:0] cell_3;
    logic [word_size-1:0] cell_2;
    logic [word_size-1:0] cell_1;
    logic [word_size-1:0] cell_0;
    logic                 clear;
    logic [word_size-1:0] th_hi;
    logic [word_size-1:0] th_lo;
    logic [word_size+1:0] sum_out;
    logic [word_size-1:0] avg_out;
    logic                 avg_valid;
    logic [word_size-1:0] peak;
    logic [2:0]           fill_count;
    logic                 alarm;
    logic [1:0]           state;

    modport master (
        output sample_valid, cell_3, cell_2, cell_1, cell_0, clear, th_hi, th_lo,
        input  sum_out, avg_out, avg_valid, peak, fill_count, alarm, state
    );

    modport slave (
        input  sample_valid, cell_3, cell_2, cell_1, cell_0, clear, th_hi, th_lo,
        output sum_out, avg_out, avg_valid, peak, fill_count, alarm, state
    );
endinterface

// File: rtl/window_averager.sv
// window_averager: 2-stage 4-sample window sum/rounded mean with peak tracking and hysteresis alarm
module window_averager #(
    parameter int word_size = 8
) (
    input  logic             clock,
    input  logic             reset,
    window_averager_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, NORMAL = 2'd1, ALARM = 2'd2} state_t;

    state_t               state, state_next;
    logic [word_size:0]   p_hi, p_lo;
    logic                 s1_valid;
    logic [2:0]           fill;
    logic [word_size+1:0] sum_next, sum_round;
    logic [word_size-1:0] avg_next;

    assign sum_next       = {1'b0, p_hi} + {1'b0, p_lo};
    assign sum_round      = sum_next + {{word_size{1'b0}}, 2'd2};
    assign avg_next       = sum_round[word_size+1:2];
    assign bus.fill_count = fill;
    assign bus.state      = state;
    assign bus.alarm      = state == ALARM;

    // Stage 1: pair-wise partial sums and window-fill tracking
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p_hi     <= '0;
            p_lo     <= '0;
            s1_valid <= 1'b0;
            fill     <= '0;
        end else if (bus.clear) begin
            s1_valid <= 1'b0;
            fill     <= '0;
        end else if (bus.sample_valid) begin
            p_hi     <= {1'b0, bus.cell_3} + {1'b0, bus.cell_2};
            p_lo     <= {1'b0, bus.cell_1} + {1'b0, bus.cell_0};
            s1_valid <= fill >= 3'd3;
            fill     <= (fill == 3'd4) ? 3'd4 : fill + 3'd1;
        end else begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: full sum, rounded mean, strobe and running peak
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.sum_out   <= '0;
            bus.avg_out   <= '0;
            bus.avg_valid <= 1'b0;
            bus.peak      <= '0;
        end else if (bus.clear) begin
            bus.avg_valid <= 1'b0;
            bus.peak      <= '0;
        end else if (s1_valid) begin
            bus.sum_out   <= sum_next;
            bus.avg_out   <= avg_next;
            bus.avg_valid <= 1'b1;
            bus.peak      <= (avg_next > bus.peak) ? avg_next : bus.peak;
        end else begin
            bus.avg_valid <= 1'b0;
        end
    end

    // Alarm FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Alarm FSM next state: moves only when a new mean leaves stage 2
    always_comb begin
        state_next = state;
        if (bus.clear) begin
            state_next = IDLE;
        end else if (s1_valid) begin
            case (state)
                IDLE, NORMAL: state_next = (avg_next > bus.th_hi) ? ALARM : NORMAL;
                ALARM:        state_next = (avg_next < bus.th_lo) ? NORMAL : ALARM;
                default:      state_next = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_window_averager.sv
// tb_window_averager: table vectors, reset corner case and randomized run against a reference model
module tb_window_averager;
    logic clock = 1'b0;
    logic reset = 1'b0;

    window_averager_if #(.word_size(8)) bus();
    window_averager #(.word_size(8)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: counts samples, holds the pending window sum, applies the mean/alarm rules
    int m_fill, m_psum, m_sum, m_avg, m_peak, m_st;
    bit m_pend, m_valid;

    typedef struct {
        bit sv;
        bit clr;
        int c3, c2, c1, c0;
        bit ev;
        int es, ea, est, ef, ep;
    } vec_t;

    vec_t tbl[$];

    task automatic model_reset();
        m_fill = 0; m_psum = 0; m_sum = 0; m_avg = 0; m_peak = 0; m_st = 0;
        m_pend = 0; m_valid = 0;
    endtask

    task automatic model_edge(bit sv, bit clr, int s, int hi, int lo);
        if (clr) begin
            m_valid = 0; m_peak = 0; m_st = 0; m_fill = 0; m_pend = 0;
        end else begin
            m_valid = m_pend;
            if (m_pend) begin
                m_sum = m_psum;
                m_avg = (m_psum + 2) / 4;
                if (m_avg > m_peak) m_peak = m_avg;
                if (m_st == 2) begin
                    if (m_avg < lo) m_st = 1;
                end else begin
                    m_st = (m_avg > hi) ? 2 : 1;
                end
            end
            m_pend = sv && (m_fill >= 3);
            if (sv) begin
                m_psum = s;
                m_fill = (m_fill < 4) ? m_fill + 1 : 4;
            end
        end
    endtask

    task automatic chk(string name, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_model(string tag);
        chk({tag, " sum_out"},    int'(bus.sum_out),    m_sum);
        chk({tag, " avg_out"},    int'(bus.avg_out),    m_avg);
        chk({tag, " avg_valid"},  int'(bus.avg_valid),  int'(m_valid));
        chk({tag, " peak"},       int'(bus.peak),       m_peak);
        chk({tag, " fill_count"}, int'(bus.fill_count), m_fill);
        chk({tag, " state"},      int'(bus.state),      m_st);
        chk({tag, " alarm"},      int'(bus.alarm),      (m_st == 2) ? 1 : 0);
    endtask

    task automatic check_zero(string tag);
        chk({tag, " sum_out"},    int'(bus.sum_out),    0);
        chk({tag, " avg_out"},    int'(bus.avg_out),    0);
        chk({tag, " avg_valid"},  int'(bus.avg_valid),  0);
        chk({tag, " peak"},       int'(bus.peak),       0);
        chk({tag, " fill_count"}, int'(bus.fill_count), 0);
        chk({tag, " state"},      int'(bus.state),      0);
        chk({tag, " alarm"},      int'(bus.alarm),      0);
    endtask

    task automatic apply(bit sv, bit clr, int c3, int c2, int c1, int c0);
        bus.sample_valid = sv;
        bus.clear        = clr;
        bus.cell_3       = 8'(c3);
        bus.cell_2       = 8'(c2);
        bus.cell_1       = 8'(c1);
        bus.cell_0       = 8'(c0);
        @(posedge clock);
        model_edge(sv, clr, c3 + c2 + c1 + c0, int'(bus.th_hi), int'(bus.th_lo));
        #1;
        bus.sample_valid = 1'b0;
        bus.clear        = 1'b0;
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.clear        = 1'b0;
        bus.cell_3       = '0;
        bus.cell_2       = '0;
        bus.cell_1       = '0;
        bus.cell_0       = '0;
        bus.th_hi        = 8'd200;
        bus.th_lo        = 8'd100;
        model_reset();

        // Expected values hand-derived: ev sum avg state fill peak after each edge
        tbl.push_back('{1, 0,   1,   0,   0,   0,  0,    0,   0, 0, 1,   0});
        tbl.push_back('{1, 0,   2,   1,   0,   0,  0,    0,   0, 0, 2,   0});
        tbl.push_back('{1, 0,   3,   2,   1,   0,  0,    0,   0, 0, 3,   0});
        tbl.push_back('{1, 0,   4,   3,   2,   1,  0,    0,   0, 0, 4,   0});
        tbl.push_back('{1, 0,   1,   1,   1,   0,  1,   10,   3, 1, 4,   3});
        tbl.push_back('{1, 0,   1,   0,   0,   0,  1,    3,   1, 1, 4,   3});
        tbl.push_back('{1, 0,   2,   2,   2,   2,  1,    1,   0, 1, 4,   3});
        tbl.push_back('{1, 1,   5,   5,   5,   5,  0,    1,   0, 0, 0,   0});
        tbl.push_back('{1, 0, 255, 255, 255, 255,  0,    1,   0, 0, 1,   0});
        tbl.push_back('{1, 0, 255, 255, 255, 255,  0,    1,   0, 0, 2,   0});
        tbl.push_back('{1, 0, 255, 255, 255, 255,  0,    1,   0, 0, 3,   0});
        tbl.push_back('{1, 0, 255, 255, 255, 255,  0,    1,   0, 0, 4,   0});
        tbl.push_back('{1, 0, 150, 150, 150, 150,  1, 1020, 255, 2, 4, 255});
        tbl.push_back('{1, 0,  99,  99,  99,  99,  1,  600, 150, 2, 4, 255});
        tbl.push_back('{1, 0,   7,   7,   7,   7,  1,  396,  99, 1, 4, 255});
        tbl.push_back('{0, 1,   0,   0,   0,   0,  0,  396,  99, 0, 0,   0});
        tbl.push_back('{0, 0,   0,   0,   0,   0,  0,  396,  99, 0, 0,   0});

        repeat (2) @(posedge clock);
        #1;
        check_zero("reset");
        reset = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i].sv, tbl[i].clr, tbl[i].c3, tbl[i].c2, tbl[i].c1, tbl[i].c0);
            chk($sformatf("vec%0d avg_valid", i),  int'(bus.avg_valid),  int'(tbl[i].ev));
            chk($sformatf("vec%0d sum_out", i),    int'(bus.sum_out),    tbl[i].es);
            chk($sformatf("vec%0d avg_out", i),    int'(bus.avg_out),    tbl[i].ea);
            chk($sformatf("vec%0d state", i),      int'(bus.state),      tbl[i].est);
            chk($sformatf("vec%0d alarm", i),      int'(bus.alarm),      (tbl[i].est == 2) ? 1 : 0);
            chk($sformatf("vec%0d fill_count", i), int'(bus.fill_count), tbl[i].ef);
            chk($sformatf("vec%0d peak", i),       int'(bus.peak),       tbl[i].ep);
        end

        // Asynchronous reset while a sample is held in stage 1
        for (int i = 0; i < 4; i++) apply(1, 0, 40, 40, 40, 40);
        apply(1, 0, 60, 60, 60, 60);
        check_model("prereset");
        #2;
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 0, 0);
            check_zero($sformatf("post_release%0d", i));
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                int a, b;
                a = int'($urandom_range(0, 255));
                b = int'($urandom_range(0, 255));
                bus.th_hi = 8'((a > b) ? a : b);
                bus.th_lo = 8'((a > b) ? b : a);
            end
            apply($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0,
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            check_model($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
